jump: RTL and testbench



---
 rtl/jump_if.sv | 22 ++
 rtl/jump.sv | 71 +++++++
 tb/tb_jump.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/jump_if.sv
// Next-PC jump-select bus: upstream next-PC candidates and control in, selected/registered PC out.
interface jump_if;
  logic        en;
  logic [31:0] previousPC4;
  logic [31:0] instruction;
  logic [31:0] MuxResult;
  logic        Jump;
  logic [31:0] nextPC;
  logic [31:0] currentPC4;
  logic        jump_taken;
  logic        illegal_jump;

  modport master (
    output en, previousPC4, instruction, MuxResult, Jump,
    input  nextPC, currentPC4, jump_taken, illegal_jump
  );

  modport slave (
    input  en, previousPC4, instruction, MuxResult, Jump,
    output nextPC, currentPC4, jump_taken, illegal_jump
  );
endinterface

// File: rtl/jump.sv
// MIPS next-PC jump-select stage: J-type target formation, target/mux select, registered next PC.
// Optional opcode qualification of Jump (J/JAL only) is enabled by defining JUMP_OPCODE_CHECK_EN.
module jump #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst_n,
  jump_if.slave bus
);

  function automatic logic is_j_opcode(input logic [5:0] opcode);
    case (opcode)
      6'b000010: return 1'b1;
      6'b000011: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  logic [31:0] target_s;
  logic        accepted_s;
  logic        illegal_s;
  logic [31:0] current_pc4_r;
  logic        jump_taken_r;
  logic        illegal_jump_r;

`ifndef JUMP_OPCODE_CHECK_EN
  logic        unused_opcode_s;
  assign unused_opcode_s = ^bus.instruction[31:26];
`endif

  // Jump target, acceptance and combinational next-PC select
  always_comb begin
    target_s   = {bus.previousPC4[31:28], bus.instruction[25:0], 2'b00};
    accepted_s = 1'b0;
    illegal_s  = 1'b0;
`ifdef JUMP_OPCODE_CHECK_EN
    accepted_s = bus.Jump & is_j_opcode(bus.instruction[31:26]);
    illegal_s  = bus.Jump & ~is_j_opcode(bus.instruction[31:26]);
`else
    accepted_s = bus.Jump;
    illegal_s  = 1'b0;
`endif
    if (accepted_s) begin
      bus.nextPC = target_s;
    end else begin
      bus.nextPC = bus.MuxResult;
    end
  end

  // Next-PC and status registers, updated together when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_pc4_r  <= RESET_PC;
      jump_taken_r   <= 1'b0;
      illegal_jump_r <= 1'b0;
    end else if (bus.en) begin
      current_pc4_r  <= bus.nextPC;
      jump_taken_r   <= accepted_s;
      illegal_jump_r <= illegal_s;
    end else begin
      current_pc4_r  <= current_pc4_r;
      jump_taken_r   <= jump_taken_r;
      illegal_jump_r <= illegal_jump_r;
    end
  end

  assign bus.currentPC4   = current_pc4_r;
  assign bus.jump_taken   = jump_taken_r;
  assign bus.illegal_jump = illegal_jump_r;

endmodule

// File: tb/tb_jump.sv
// Directed self-checking bench for jump; expectations follow the build's JUMP_OPCODE_CHECK_EN setting.
module tb_jump;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  jump_if jif ();

  jump #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (jif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks = n_checks + 1;
    if (actual !== expected) begin
      n_fails = n_fails + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] prev, input logic [31:0] instr,
                       input logic [31:0] mux, input logic jmp);
    jif.en          = en;
    jif.previousPC4 = prev;
    jif.instruction = instr;
    jif.MuxResult   = mux;
    jif.Jump        = jmp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] pc, input logic jt, input logic ij);
    check_eq({tag, "_pc"}, jif.currentPC4, pc);
    check_eq({tag, "_jt"}, {31'd0, jif.jump_taken}, {31'd0, jt});
    check_eq({tag, "_ij"}, {31'd0, jif.illegal_jump}, {31'd0, ij});
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b1);
    #2;
    check_regs("reset_immediate", 32'h0000_0000, 1'b0, 1'b0);
    step();
    check_regs("reset_over_en", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // No jump
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b0);
    #1;
    check_eq("nojump_next", jif.nextPC, 32'h0000_0008);
    step();
    check_regs("nojump", 32'h0000_0008, 1'b0, 1'b0);

    // Jump
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b1);
    #1;
    check_eq("jump_next", jif.nextPC, 32'h0000_0040);
    step();
    check_regs("jump", 32'h0000_0040, 1'b1, 1'b0);

    // Upper-nibble merge, full index
    @(negedge clk);
    drive(1'b1, 32'hA000_0004, 32'h0BFF_FFFF, 32'h0000_0008, 1'b1);
    #1;
    check_eq("nibble_next", jif.nextPC, 32'hAFFF_FFFC);
    step();
    check_regs("nibble", 32'hAFFF_FFFC, 1'b1, 1'b0);

    // JAL opcode, different nibble
    @(negedge clk);
    drive(1'b1, 32'h5000_0100, 32'h0C00_0020, 32'h1234_5678, 1'b1);
    #1;
    check_eq("jal_next", jif.nextPC, 32'h5000_0080);
    step();
    check_regs("jal", 32'h5000_0080, 1'b1, 1'b0);

    // Jump=0 ignores instruction contents
    @(negedge clk);
    drive(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b0);
    #1;
    check_eq("nojump_allones_next", jif.nextPC, 32'h0000_1234);

    // Capture 0x40 then stall
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b1);
    step();
    check_regs("pre_stall", 32'h0000_0040, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b0);
    #1;
    check_eq("stall_next", jif.nextPC, 32'h0000_0008);
    for (int i = 0; i < 3; i++) begin
      step();
      check_regs("stall_hold", 32'h0000_0040, 1'b1, 1'b0);
    end

    // Jump on R-type opcode
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0000_0010, 32'h0000_0008, 1'b1);
    #1;
`ifdef JUMP_OPCODE_CHECK_EN
    check_eq("rtype_next", jif.nextPC, 32'h0000_0008);
    step();
    check_regs("rtype", 32'h0000_0008, 1'b0, 1'b1);
`else
    check_eq("rtype_next", jif.nextPC, 32'h0000_0040);
    step();
    check_regs("rtype", 32'h0000_0040, 1'b1, 1'b0);
`endif

    // illegal_jump lasts one captured cycle
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0000_0010, 32'h0000_0010, 1'b0);
    step();
    check_regs("after_rtype", 32'h0000_0010, 1'b0, 1'b0);

    // Reset asserted mid-stall, held value not restored
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b1);
    step();
    @(negedge clk);
    drive(1'b0, 32'h0000_0004, 32'h0800_0010, 32'h0000_0008, 1'b1);
    step();
    check_regs("stall2_hold", 32'h0000_0040, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_regs("reset_midstall", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_regs("post_reset_stall", 32'h0000_0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h0000_0004, 32'h0800_0010, 32'h0000_0100, 1'b0);
    step();
    check_regs("post_reset_capture", 32'h0000_0100, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
